// File: rtl/load_store_unit_if.sv
// Request/response and data_mem signals between execute, load_store_unit and data_mem.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_illegal;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_illegal,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: alignment/funct3 checks, extended loads, SB/SH via read-modify-write.
module load_store_unit #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    load_store_unit_if.slave bus
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT);

    typedef enum logic [2:0] {
        S_IDLE, S_FAULT, S_LD, S_SW, S_RMW_RD, S_RMW_WR, S_DONE
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       lane_q, lane_d;
    logic [15:0]      wdata_q, wdata_d;

    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_mis_q, resp_mis_d;
    logic        resp_ill_q, resp_ill_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic        accept_c;
    logic        illegal_c;
    logic        misaligned_c;
    logic        last_rd_c;
    logic [31:0] load_ext_c;
    logic [31:0] merged_c;

    assign accept_c  = bus.req_valid && req_ready_q;
    assign last_rd_c = (cnt_q == CNT_LAST);

    // Legality and alignment of the incoming request
    always_comb begin
        if (bus.req_we) begin
            illegal_c = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            illegal_c = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        end
        misaligned_c = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    end

    // Lane select/extension for loads and byte/half merge for RMW stores
    always_comb begin
        logic [31:0] shifted;
        logic [15:0] half;
        logic [4:0]  bsh;
        logic [4:0]  hsh;
        bsh     = {lane_q, 3'b000};
        hsh     = {lane_q[1], 4'b0000};
        shifted = bus.mem_rdata >> bsh;
        half    = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (f3_q)
            3'b000:  load_ext_c = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext_c = {{16{half[15]}}, half};
            3'b010:  load_ext_c = bus.mem_rdata;
            3'b100:  load_ext_c = {24'h0, shifted[7:0]};
            3'b101:  load_ext_c = {16'h0, half};
            default: load_ext_c = 32'h0;
        endcase
        if (f3_q == 3'b000) begin
            merged_c = (bus.mem_rdata & ~(32'h0000_00FF << bsh)) | ({24'h0, wdata_q[7:0]} << bsh);
        end else begin
            merged_c = (bus.mem_rdata & ~(32'h0000_FFFF << hsh)) | ({16'h0, wdata_q} << hsh);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (illegal_c || misaligned_c)     state_d = S_FAULT;
                    else if (!bus.req_we)              state_d = S_LD;
                    else if (bus.req_funct3 == 3'b010) state_d = S_SW;
                    else                               state_d = S_RMW_RD;
                end
            end
            S_FAULT:  state_d = S_IDLE;
            S_LD:     if (last_rd_c) state_d = S_DONE;
            S_SW:     state_d = S_DONE;
            S_RMW_RD: if (last_rd_c) state_d = S_RMW_WR;
            S_RMW_WR: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; outputs are decoded from the next state so they register in step
    always_comb begin
        cnt_d        = '0;
        f3_d         = f3_q;
        lane_d       = lane_q;
        wdata_d      = wdata_q;
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_FAULT) || (state_d == S_DONE);
        resp_rdata_d = 32'h0;
        resp_mis_d   = 1'b0;
        resp_ill_d   = 1'b0;
        mem_read_d   = (state_d == S_LD) || (state_d == S_RMW_RD);
        mem_write_d  = (state_d == S_SW) || (state_d == S_RMW_WR);
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        if ((state_q == S_LD || state_q == S_RMW_RD) && !last_rd_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (accept_c) begin
            f3_d    = bus.req_funct3;
            lane_d  = bus.req_addr[1:0];
            wdata_d = bus.req_wdata[15:0];
            if (state_d == S_FAULT) begin
                resp_ill_d = illegal_c;
                resp_mis_d = !illegal_c && misaligned_c;
            end else begin
                mem_addr_d = {bus.req_addr[31:2], 2'b00};
                if (state_d == S_SW) mem_wdata_d = bus.req_wdata;
            end
        end

        if (state_q == S_LD && last_rd_c)     resp_rdata_d = load_ext_c;
        if (state_q == S_RMW_RD && last_rd_c) mem_wdata_d  = merged_c;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            f3_q         <= '0;
            lane_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
            resp_ill_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            lane_q       <= lane_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
            resp_ill_q   <= resp_ill_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_rdata      = resp_rdata_q;
    assign bus.resp_misaligned = resp_mis_q;
    assign bus.resp_illegal    = resp_ill_q;
    assign bus.mem_read        = mem_read_q;
    assign bus.mem_write       = mem_write_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_wdata       = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: MEM_LAT=1 and MEM_LAT=3 instances, each with a word memory model.
module tb_load_store_unit;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        ill;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    logic [31:0] exp_addr0 = 32'h0, exp_addr1 = 32'h0;
    int rd_cnt0 = 0, wr_cnt0 = 0, rd_cnt1 = 0, wr_cnt1 = 0;
    int last_wr0 = 0, last_wr1 = 0;
    int addr_bad = 0, both_bad = 0;

    logic [31:0] mem0 [16];
    logic [31:0] mem1 [16];

    load_store_unit_if bus0();
    load_store_unit_if bus1();

    load_store_unit #(.MEM_LAT(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    load_store_unit #(.MEM_LAT(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // data_mem models: combinational read, full-word write on the edge
    assign bus0.mem_rdata = mem0[bus0.mem_addr[5:2]];
    assign bus1.mem_rdata = mem1[bus1.mem_addr[5:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) begin
                mem0[i] <= 32'h0;
                mem1[i] <= 32'h0;
            end
        end else begin
            if (bus0.mem_write) mem0[bus0.mem_addr[5:2]] <= bus0.mem_wdata;
            if (bus1.mem_write) mem1[bus1.mem_addr[5:2]] <= bus1.mem_wdata;
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Monitor dut0: response scoreboard plus memory-port bookkeeping
    always @(negedge clk) begin
        if (bus0.mem_read) rd_cnt0++;
        if (bus0.mem_write) begin
            wr_cnt0++;
            last_wr0 = cyc;
        end
        if (bus0.mem_read && bus0.mem_write) both_bad++;
        if ((bus0.mem_read || bus0.mem_write) && bus0.mem_addr !== exp_addr0) addr_bad++;
        if (bus0.resp_valid) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut0_unexpected_resp actual=resp_valid required=none cyc=%0d", cyc);
            end else begin
                e0 = q0.pop_front();
                check("dut0_rdata", bus0.resp_rdata, e0.rdata);
                check("dut0_misaligned", 32'(bus0.resp_misaligned), 32'(e0.mis));
                check("dut0_illegal", 32'(bus0.resp_illegal), 32'(e0.ill));
                check("dut0_resp_cycle", 32'(cyc), 32'(e0.cyc));
            end
        end
    end

    // Monitor dut1
    always @(negedge clk) begin
        if (bus1.mem_read) rd_cnt1++;
        if (bus1.mem_write) begin
            wr_cnt1++;
            last_wr1 = cyc;
        end
        if (bus1.mem_read && bus1.mem_write) both_bad++;
        if ((bus1.mem_read || bus1.mem_write) && bus1.mem_addr !== exp_addr1) addr_bad++;
        if (bus1.resp_valid) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL dut1_unexpected_resp actual=resp_valid required=none cyc=%0d", cyc);
            end else begin
                e1 = q1.pop_front();
                check("dut1_rdata", bus1.resp_rdata, e1.rdata);
                check("dut1_misaligned", 32'(bus1.resp_misaligned), 32'(e1.mis));
                check("dut1_illegal", 32'(bus1.resp_illegal), 32'(e1.ill));
                check("dut1_resp_cycle", 32'(cyc), 32'(e1.cyc));
            end
        end
    end

    task automatic issue(input int d, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit exp_mis,
                         input bit exp_ill, input int lat, input bit push, output int t);
        exp_t e;
        bit   ok;
        @(posedge clk);
        #1;
        if (d == 0) begin
            bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_funct3 = f3;
            bus0.req_addr = addr;  bus0.req_wdata = wdata;
            exp_addr0 = {addr[31:2], 2'b00};
        end else begin
            bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_funct3 = f3;
            bus1.req_addr = addr;  bus1.req_wdata = wdata;
            exp_addr1 = {addr[31:2], 2'b00};
        end
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if ((d == 0) ? bus0.req_ready : bus1.req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout actual=req_ready_low required=req_ready_high dut=%0d", d);
        end
        t = cyc;
        e.rdata = exp_rdata; e.mis = exp_mis; e.ill = exp_ill; e.cyc = t + lat;
        if (push && ok) begin
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(posedge clk);
        #1;
        if (d == 0) bus0.req_valid = 1'b0;
        else        bus1.req_valid = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (((d == 0) ? q0.size() : q1.size()) == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout actual=no_resp required=resp dut=%0d", d);
            if (d == 0) q0.delete();
            else        q1.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int t, rd_s, wr_s;
        rst = 1'b1;
        mem_clr = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_funct3 = 3'b0;
        bus0.req_addr = 32'h0; bus0.req_wdata = 32'h0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_funct3 = 3'b0;
        bus1.req_addr = 32'h0; bus1.req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        mem_clr = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(bus0.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus0.resp_valid), 32'd0);
        check("rst_resp_rdata", bus0.resp_rdata, 32'h0);
        check("rst_mem_read", 32'(bus0.mem_read), 32'd0);
        check("rst_mem_write", 32'(bus0.mem_write), 32'd0);
        check("rst_mem_addr", bus0.mem_addr, 32'h0);
        check("rst_mem_wdata", bus0.mem_wdata, 32'h0);
        check("rst_flags", 32'({bus0.resp_misaligned, bus0.resp_illegal}), 32'd0);
        check("rst_req_ready_lat3", 32'(bus1.req_ready), 32'd1);

        // SW then LW
        issue(0, 1'b1, 3'b010, 32'h4, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 2, 1'b1, t);
        wait_idle(0);
        check("sw_mem_word", mem0[1], 32'hDEADBEEF);
        rd_s = rd_cnt0;
        issue(0, 1'b0, 3'b010, 32'h4, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 3, 1'b1, t);
        wait_idle(0);
        check("lw_read_cycles", 32'(rd_cnt0 - rd_s), 32'd2);

        // Byte/half loads with extension
        issue(0, 1'b0, 3'b000, 32'h7, 32'h0, 32'hFFFFFFDE, 1'b0, 1'b0, 3, 1'b1, t); wait_idle(0);
        issue(0, 1'b0, 3'b100, 32'h7, 32'h0, 32'h000000DE, 1'b0, 1'b0, 3, 1'b1, t); wait_idle(0);
        issue(0, 1'b0, 3'b001, 32'h6, 32'h0, 32'hFFFFDEAD, 1'b0, 1'b0, 3, 1'b1, t); wait_idle(0);
        issue(0, 1'b0, 3'b101, 32'h4, 32'h0, 32'h0000BEEF, 1'b0, 1'b0, 3, 1'b1, t); wait_idle(0);

        // RMW stores
        issue(0, 1'b1, 3'b000, 32'h5, 32'hFFFFFFAA, 32'h0, 1'b0, 1'b0, 4, 1'b1, t); wait_idle(0);
        check("sb_write_cycle", 32'(last_wr0), 32'(t + 3));
        issue(0, 1'b0, 3'b010, 32'h4, 32'h0, 32'hDEADAAEF, 1'b0, 1'b0, 3, 1'b1, t); wait_idle(0);
        issue(0, 1'b1, 3'b010, 32'h8, 32'h12345678, 32'h0, 1'b0, 1'b0, 2, 1'b1, t); wait_idle(0);
        issue(0, 1'b1, 3'b001, 32'hA, 32'h0000CAFE, 32'h0, 1'b0, 1'b0, 4, 1'b1, t); wait_idle(0);
        check("sh_write_cycle", 32'(last_wr0), 32'(t + 3));
        issue(0, 1'b0, 3'b010, 32'h8, 32'h0, 32'hCAFE5678, 1'b0, 1'b0, 3, 1'b1, t); wait_idle(0);

        // Faults: no memory traffic at all
        rd_s = rd_cnt0;
        wr_s = wr_cnt0;
        issue(0, 1'b0, 3'b010, 32'h6, 32'h0, 32'h0, 1'b1, 1'b0, 1, 1'b1, t); wait_idle(0);
        issue(0, 1'b1, 3'b001, 32'h9, 32'h1234, 32'h0, 1'b1, 1'b0, 1, 1'b1, t); wait_idle(0);
        issue(0, 1'b0, 3'b011, 32'h5, 32'h0, 32'h0, 1'b0, 1'b1, 1, 1'b1, t); wait_idle(0);
        issue(0, 1'b1, 3'b101, 32'h3, 32'h0, 32'h0, 1'b0, 1'b1, 1, 1'b1, t); wait_idle(0);
        issue(0, 1'b0, 3'b001, 32'h5, 32'h0, 32'h0, 1'b1, 1'b0, 1, 1'b1, t); wait_idle(0);
        check("fault_no_read", 32'(rd_cnt0 - rd_s), 32'd0);
        check("fault_no_write", 32'(wr_cnt0 - wr_s), 32'd0);

        // Reset during RMW_RD of SB 0x4
        wr_s = wr_cnt0;
        issue(0, 1'b1, 3'b000, 32'h4, 32'h00000077, 32'h0, 1'b0, 1'b0, 4, 1'b0, t);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_req_ready", 32'(bus0.req_ready), 32'd1);
        check("rst_mid_mem_write", 32'(bus0.mem_write), 32'd0);
        repeat (6) @(negedge clk);
        check("rst_mid_no_write", 32'(wr_cnt0 - wr_s), 32'd0);
        issue(0, 1'b0, 3'b010, 32'h4, 32'h0, 32'hDEADAAEF, 1'b0, 1'b0, 3, 1'b1, t); wait_idle(0);

        // MEM_LAT=3 instance
        issue(1, 1'b1, 3'b010, 32'h0, 32'h11223344, 32'h0, 1'b0, 1'b0, 2, 1'b1, t); wait_idle(1);
        rd_s = rd_cnt1;
        issue(1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h11223344, 1'b0, 1'b0, 5, 1'b1, t); wait_idle(1);
        check("lat3_lw_read_cycles", 32'(rd_cnt1 - rd_s), 32'd4);
        issue(1, 1'b1, 3'b000, 32'h3, 32'h00000055, 32'h0, 1'b0, 1'b0, 6, 1'b1, t); wait_idle(1);
        check("lat3_sb_write_cycle", 32'(last_wr1), 32'(t + 5));
        issue(1, 1'b0, 3'b010, 32'h0, 32'h0, 32'h55223344, 1'b0, 1'b0, 5, 1'b1, t); wait_idle(1);
        issue(1, 1'b0, 3'b001, 32'h2, 32'h0, 32'h00005522, 1'b0, 1'b0, 5, 1'b1, t); wait_idle(1);

        check("mem_addr_stable", 32'(addr_bad), 32'd0);
        check("rd_wr_exclusive", 32'(both_bad), 32'd0);
        check("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit between the execute stage and `data_mem`. It takes one memory request per transaction (address, funct3, store data) and returns sign- or zero-extended load data. `data_mem` only performs full-word writes, so SB and SH are done as a read-modify-write. The unit checks alignment and funct3 legality before any memory access.

## Interface
- `MEM_LAT`, default 1: extra cycles `mem_read` is held before `mem_rdata` is sampled (range 0–7).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  1  request present; accepted when `req_valid && req_ready`.
- `req_ready`  out  1  high only in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I funct3:
  - loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - stores: SB=000, SH=001, SW=010.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_misaligned`  out  1  valid with `resp_valid`.
- `resp_illegal`  out  1  valid with `resp_valid`.
- `mem_read`  out  1  to `data_mem.mem_read`.
- `mem_write`  out  1  to `data_mem.mem_write`.
- `mem_addr`  out  32  to `data_mem.addr`; always word-aligned, `{req_addr[31:2],2'b00}`.
- `mem_wdata`  out  32  to `data_mem.write_data`.
- `mem_rdata`  in  32  from `data_mem.read_data`.

## Operation
- All outputs are registered. Request fields are latched on accept.
- Byte lanes are little-endian: lane = `addr[1:0]`; halfword lane = `addr[1]`.
- Check order at accept:
  - Illegal funct3 (load 011/110/111; store other than 000/001/010) → FAULT with `resp_illegal`=1.
  - Else misaligned (H: `addr[0]`≠0; W: `addr[1:0]`≠0) → FAULT with `resp_misaligned`=1.
  - Illegal takes priority over misaligned.
- States:
  - IDLE: `req_ready`=1. Accept goes to FAULT, LD, SW, or RMW_RD.
  - FAULT: `resp_valid`=1 with the fault flag → IDLE. No memory access.
  - LD: `mem_read`=1 for MEM_LAT+1 cycles (counter). `mem_rdata` is sampled on the last cycle, lane-selected and extended (LB/LH sign, LBU/LHU zero) → DONE.
  - SW: `mem_write`=1 with `mem_wdata`=`req_wdata` for one cycle → DONE.
  - RMW_RD: same read timing as LD. Merge the sampled word:
    - SB: replace byte at lane with `wdata[7:0]`.
    - SH: replace half at lane with `wdata[15:0]`.
    - → RMW_WR.
  - RMW_WR: `mem_write`=1 with the merged word for one cycle → DONE.
  - DONE: `resp_valid`=1 → IDLE.
- `mem_read` and `mem_write` are never high in the same cycle. `mem_addr` is stable throughout a transaction.
- In IDLE, FAULT and DONE: `mem_read`=`mem_write`=0. `mem_addr` and `mem_wdata` hold their last value.

## Timing
- Request accepted at edge T (cycle T).
- FAULT: `resp_valid` in cycle T+1.
- SW: `mem_write` in T+1; `resp_valid` in T+2.
- Load: `mem_read` in T+1 … T+1+MEM_LAT; `resp_valid` in T+MEM_LAT+2. Default MEM_LAT=1 gives T+3.
- SB/SH: read T+1 … T+1+MEM_LAT; `mem_write` in T+MEM_LAT+2; `resp_valid` in T+MEM_LAT+3. Default gives T+4.
- Back-to-back: next accept is possible the cycle after `resp_valid`.
- `req_valid` is ignored while `req_ready`=0.
- Reset values: state=IDLE, `req_ready`=1, and every other output (`resp_*`, `mem_*`) = 0.
- Reset mid-transaction: rst sampled high at an edge takes effect at that edge.
  - The transaction is abandoned and no response is issued.
  - `mem_write` is 0 from the cycle after that edge. An RMW aborted before RMW_WR never writes memory.

## Test plan
1. SW 0x4 = 0xDEADBEEF, then LW 0x4 → `resp_rdata`=0xDEADBEEF at T+3; `mem_addr`=0x4 throughout.
2. With word 0x4 = 0xDEADBEEF:
   - LB 0x7 → 0xFFFFFFDE
   - LBU 0x7 → 0x000000DE
   - LH 0x6 → 0xFFFFDEAD
   - LHU 0x4 → 0x0000BEEF
3. RMW stores, then LW to check:
   - SB 0x5 with `wdata`=0x000000AA → LW 0x4 = 0xDEADAAEF.
   - Word 0x8 = 0x12345678; SH 0xA with 0x0000CAFE → LW 0x8 = 0xCAFE5678.
   - Write occurs at T+3; `resp_valid` at T+4.
4. Faults, no memory access at all:
   - LW 0x6 → `resp_misaligned`=1 at T+1; `mem_read`/`mem_write` stay 0.
   - SH 0x9 → `resp_misaligned`=1 at T+1; `mem_read`/`mem_write` stay 0.
   - Load funct3=011 at 0x5 → `resp_illegal`=1, `resp_misaligned`=0.
5. Reset during RMW_RD of SB 0x4 → no `mem_write` pulse, no `resp_valid`; `req_ready`=1 the cycle after reset; LW 0x4 then returns the unmodified word.
6. MEM_LAT=3 build: LW → `mem_read` high 4 cycles, `resp_valid` at T+5; SB → `mem_write` at T+5, `resp_valid` at T+6.
